seg7_scanner: RTL



---
 rtl/seg7_scanner.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/seg7_scanner.sv
// seg7_scanner: four-digit multiplexed seven-segment driver.
// Scans a 16-bit hex value one digit per scan tick. Each new digit is preceded
// by DEAD_CYCLES cycles with every anode off, so the previous digit cannot
// ghost. The value is captured once per frame, so a frame never tears.
// Leading zeros can optionally be blanked.
//
// Ports:
//   clk       system clock
//   rst       synchronous, active-high reset
//   clk_div   slow divided clock; sampled only to detect rising edges (scan tick)
//   value     16-bit hex value; nibble k drives digit k (digit 3 is leftmost)
//   dp        decimal point per digit
//   blank_lz  leading-zero blanking enable
//   an        digit enables, one-hot when active (polarity per ACTIVE_LOW_AN)
//   seg       segments, bit0 = a .. bit6 = g (polarity per ACTIVE_LOW_SEG)
//   seg_dp    decimal point segment (polarity per ACTIVE_LOW_SEG)
//   digit_idx digit currently shown or being prepared
module seg7_scanner #(
  parameter int unsigned DEAD_CYCLES    = 4,
  parameter bit          ACTIVE_LOW_SEG = 1'b1,
  parameter bit          ACTIVE_LOW_AN  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_div,
  input  logic [15:0] value,
  input  logic [3:0]  dp,
  input  logic        blank_lz,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        seg_dp,
  output logic [1:0]  digit_idx
);

  localparam logic [7:0] DEAD_LAST = 8'(DEAD_CYCLES - 1);
  localparam logic [3:0] AN_OFF    = ACTIVE_LOW_AN  ? 4'hF  : 4'h0;
  localparam logic [6:0] SEG_OFF   = ACTIVE_LOW_SEG ? 7'h7F : 7'h00;
  localparam logic       DP_OFF    = ACTIVE_LOW_SEG;

  typedef enum logic [1:0] {S_IDLE, S_BLANK, S_SHOW} state_t;

  state_t      r_state, w_state_nx;
  logic [1:0]  r_idx, w_idx_nx;
  logic [7:0]  r_cnt, w_cnt_nx;
  logic        w_load;

  logic        r_clk_div_s, r_clk_div_q;
  logic        w_tick;

  logic [15:0] r_val;
  logic [3:0]  r_dp;
  logic        r_blz;

  logic        w_lz_blank, w_show;
  logic [3:0]  w_nib;
  logic [3:0]  w_an_ah;
  logic [6:0]  w_seg_ah;
  logic        w_dp_ah;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;
      4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;
      4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;
      4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;
      4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
    endcase
  endfunction

  // clk_div is registered first, then edge-detected on the registered copy,
  // giving one cycle between clk_div being sampled and the state change.
  // Both flops reset high so a clk_div held high through reset is not a tick.
  assign w_tick = r_clk_div_s & ~r_clk_div_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_clk_div_s <= 1'b1;
      r_clk_div_q <= 1'b1;
    end else begin
      r_clk_div_s <= clk_div;
      r_clk_div_q <= r_clk_div_s;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_idx   <= 2'd0;
      r_cnt   <= 8'd0;
    end else begin
      r_state <= w_state_nx;
      r_idx   <= w_idx_nx;
      r_cnt   <= w_cnt_nx;
    end
  end

  // Next state; ticks arriving in BLANK fall through the default and are lost.
  always_comb begin
    w_state_nx = r_state;
    w_idx_nx   = r_idx;
    w_cnt_nx   = r_cnt;
    w_load     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_tick) begin
          w_state_nx = S_BLANK;
          w_idx_nx   = 2'd0;
          w_cnt_nx   = 8'd0;
          w_load     = 1'b1;
        end
      end
      S_BLANK: begin
        if (r_cnt == DEAD_LAST) begin
          w_state_nx = S_SHOW;
          w_cnt_nx   = 8'd0;
        end else begin
          w_cnt_nx = r_cnt + 8'd1;
        end
      end
      S_SHOW: begin
        if (w_tick) begin
          w_state_nx = S_BLANK;
          w_idx_nx   = r_idx + 2'd1;
          w_cnt_nx   = 8'd0;
          w_load     = (r_idx == 2'd3);
        end
      end
      default: begin
        w_state_nx = S_IDLE;
        w_idx_nx   = 2'd0;
        w_cnt_nx   = 8'd0;
      end
    endcase
  end

  // Shadow copies: the only source of displayed data.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_val <= 16'h0000;
      r_dp  <= 4'h0;
      r_blz <= 1'b0;
    end else if (w_load) begin
      r_val <= value;
      r_dp  <= dp;
      r_blz <= blank_lz;
    end
  end

  // Output data is a function of the next state. SHOW is only entered from
  // BLANK (or held), where index and shadows are stable, so the current
  // index and shadows are the right ones to decode.
  always_comb begin
    w_lz_blank = 1'b0;
    w_nib      = r_val[3:0];
    case (r_idx)
      2'd1: begin w_lz_blank = r_blz && (r_val[15:4]  == 12'h000); w_nib = r_val[7:4];   end
      2'd2: begin w_lz_blank = r_blz && (r_val[15:8]  == 8'h00);   w_nib = r_val[11:8];  end
      2'd3: begin w_lz_blank = r_blz && (r_val[15:12] == 4'h0);    w_nib = r_val[15:12]; end
      default: ;
    endcase
    w_show   = (w_state_nx == S_SHOW) && !w_lz_blank;
    w_an_ah  = w_show ? 4'(4'b0001 << r_idx) : 4'h0;
    w_seg_ah = w_show ? hex7(w_nib) : 7'h00;
    w_dp_ah  = w_show ? r_dp[r_idx] : 1'b0;
  end

  // Registered outputs; polarity applied last.
  always_ff @(posedge clk) begin
    if (rst) begin
      an     <= AN_OFF;
      seg    <= SEG_OFF;
      seg_dp <= DP_OFF;
    end else begin
      an     <= w_an_ah ^ AN_OFF;
      seg    <= w_seg_ah ^ SEG_OFF;
      seg_dp <= w_dp_ah ^ DP_OFF;
    end
  end

  assign digit_idx = r_idx;

endmodule
